axi_addr_remap_slice: RTL and testbench
=======================================

AXI_ADDR_REMAP_SLICE -- requirements
Module: axi_addr_remap_slice

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 The block SHALL have parameter LEN_W, default 8, burst length width.
REQ-003 The block SHALL have parameter ADDR_OFFSET, default 32'h40000000, constant added to every forwarded address.
REQ-004 The block SHALL have parameter MAX_OUT, default 8, range 1..255, maximum outstanding transactions per direction.
REQ-005 The block SHALL have parameter WIN_SIZE, default 32'h10000000, legal upstream address window [0, WIN_SIZE).
REQ-006 The block SHALL have port user_clk, input, 1 bit, the single clock.
REQ-007 The block SHALL have port user_reset_n, input, 1 bit, reset (asynchronous, active-low).
REQ-008 The block SHALL have ports s_arvalid in 1, s_arready out 1, s_araddr in ADDR_W, s_arlen in LEN_W, s_arsize in 3, s_arburst in 2, forming the upstream read-address channel.
REQ-009 The block SHALL have ports s_awvalid, s_awready, s_awaddr, s_awlen, s_awsize, s_awburst, with the same widths, forming the upstream write-address channel.
REQ-010 The block SHALL have ports m_arvalid out, m_arready in, m_araddr, m_arlen, m_arsize, m_arburst (all out), forming the downstream read-address channel; m_aw* SHALL mirror this for writes.
REQ-011 The block SHALL have ports mon_rvalid, mon_rready, mon_rlast, mon_bvalid, mon_bready, input, 1 bit each, which observe the R and B handshakes.
REQ-012 The block SHALL have ports rd_outstanding and wr_outstanding, output, 8 bits each, carrying the live outstanding counts.
REQ-013 The block SHALL have ports err_valid out 1, err_addr out ADDR_W and err_clr in 1, forming the window-violation report (see REQ-024).

Function
REQ-014 Each of the AR and AW paths SHALL be an independent 2-entry skid buffer (main plus skid register) sustaining one transfer per cycle.
REQ-015 The address field SHALL be captured as s_addr + ADDR_OFFSET, truncated modulo 2^ADDR_W (wrap-around, no carry out); len, size and burst SHALL pass unchanged.
REQ-016 Forward latency SHALL be exactly 1 cycle: an s_* handshake in cycle N SHALL make m_*valid high in cycle N+1 when the buffer was empty.
REQ-017 Once asserted, m_*valid and m_* payload SHALL be held stable until m_*ready is sampled high.
REQ-018 s_*ready SHALL be a registered signal, low whenever the skid entry is occupied.
REQ-019 Per path, the buffer state SHALL be EMPTY, ONE (main valid) or TWO (main+skid valid); a simultaneous push and pop in ONE SHALL remain in ONE, and a pop in TWO SHALL move the skid entry to main.
REQ-020 rd_outstanding SHALL increment on an m_ar handshake and decrement on mon_rvalid&mon_rready&mon_rlast; when both occur in the same cycle it SHALL stay unchanged.
REQ-021 wr_outstanding SHALL increment on an m_aw handshake and decrement on mon_bvalid&mon_bready, with the same simultaneous-event rule as REQ-020.
REQ-022 When (outstanding + occupied buffer entries) >= MAX_OUT for a direction, s_*ready for that direction SHALL be low; the count SHALL never exceed MAX_OUT.
REQ-023 A decrement arriving while the count is 0 SHALL be ignored (the counter saturates at 0).

Reset
REQ-025 Asserting user_reset_n low SHALL immediately clear all valid bits, counters, err_valid and err_addr to 0, and drive s_*ready low.
REQ-026 s_*ready SHALL rise on the first clock edge after user_reset_n deasserts.
REQ-027 A reset asserted mid-burst SHALL discard buffered requests without emitting them.

Configuration
REQ-024 When macro REMAP_WINDOW_CHECK_EN is defined, a request accepted with s_addr >= WIN_SIZE SHALL still be forwarded, and if err_valid is 0 it SHALL set err_valid=1 and latch the unmodified s_addr into err_addr (first error wins; AR has priority over AW in the same cycle); err_clr SHALL clear err_valid, and a new violation in the err_clr cycle SHALL win over the clear.
REQ-028 When REMAP_WINDOW_CHECK_EN is undefined, the window-check logic SHALL be absent and err_valid and err_addr SHALL be tied to 0.

Verification
REQ-029 The bench SHALL cover this scenario: s_araddr=0x00001000, m_arready=1 -> m_araddr=0x40001000 one cycle later, rd_outstanding=1.
REQ-030 The bench SHALL cover this scenario: m_awready held 0 while 3 back-to-back AW requests are presented -> 2 accepted, s_awready=0, payload stable; on release, all emitted in order.
REQ-031 The bench SHALL cover this scenario: MAX_OUT=2, 2 reads issued with no R last -> s_arready=0; one mon_rlast handshake -> s_arready=1 next cycle.
REQ-032 The bench SHALL cover this scenario: s_araddr=0xC0000010 -> m_araddr=0x00000010 (wrap).
REQ-033 The bench SHALL cover this scenario, with REMAP_WINDOW_CHECK_EN defined: s_awaddr=0x20000000 -> err_valid=1, err_addr=0x20000000; a second violation leaves err_addr unchanged; err_clr -> err_valid=0.
REQ-034 The bench SHALL cover this scenario: user_reset_n pulsed low with both buffers in TWO -> m_*valid=0 and counters=0 immediately, and no stale request appears after release.

Source files
------------

// File: rtl/axi_addr_remap_slice_if.sv
// One AXI address channel (AR or AW): valid/ready handshake plus address-phase payload.
interface axi_addr_remap_slice_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 8
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;

    modport master (output valid, addr, len, size, burst, input ready);
    modport slave  (input valid, addr, len, size, burst, output ready);
endinterface

// File: rtl/axi_addr_remap_slice.sv
// AR/AW register slices that add ADDR_OFFSET to each address and limit outstanding transactions.
// Optional window-violation reporting is built when REMAP_WINDOW_CHECK_EN is defined.
module axi_addr_remap_slice #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       LEN_W       = 8,
    parameter logic [ADDR_W-1:0] ADDR_OFFSET = 32'h4000_0000,
    parameter int unsigned       MAX_OUT     = 8,
    parameter logic [ADDR_W-1:0] WIN_SIZE    = 32'h1000_0000
) (
    input  logic                   user_clk,
    input  logic                   user_reset_n,
    axi_addr_remap_slice_if.slave  s_ar,
    axi_addr_remap_slice_if.slave  s_aw,
    axi_addr_remap_slice_if.master m_ar,
    axi_addr_remap_slice_if.master m_aw,
    input  logic                   mon_rvalid,
    input  logic                   mon_rready,
    input  logic                   mon_rlast,
    input  logic                   mon_bvalid,
    input  logic                   mon_bready,
    output logic [7:0]             rd_outstanding,
    output logic [7:0]             wr_outstanding,
    output logic                   err_valid,
    output logic [ADDR_W-1:0]      err_addr,
    input  logic                   err_clr
);

    localparam int unsigned PW     = ADDR_W + LEN_W + 5;
    localparam logic [9:0]  MaxOut = 10'(MAX_OUT);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    // Index 0 is the read (AR) path, index 1 the write (AW) path.
    logic [1:0]    in_valid, in_ready, out_valid, out_ready, dec_ev;
    logic [PW-1:0] in_payload  [2];
    logic [PW-1:0] out_payload [2];
    logic [7:0]    count       [2];

    assign in_valid  = {s_aw.valid, s_ar.valid};
    assign out_ready = {m_aw.ready, m_ar.ready};
    assign dec_ev    = {mon_bvalid & mon_bready, mon_rvalid & mon_rready & mon_rlast};

    assign in_payload[0] = {s_ar.addr + ADDR_OFFSET, s_ar.len, s_ar.size, s_ar.burst};
    assign in_payload[1] = {s_aw.addr + ADDR_OFFSET, s_aw.len, s_aw.size, s_aw.burst};

    assign s_ar.ready = in_ready[0];
    assign s_aw.ready = in_ready[1];
    assign m_ar.valid = out_valid[0];
    assign m_aw.valid = out_valid[1];
    assign {m_ar.addr, m_ar.len, m_ar.size, m_ar.burst} = out_payload[0];
    assign {m_aw.addr, m_aw.len, m_aw.size, m_aw.burst} = out_payload[1];
    assign rd_outstanding = count[0];
    assign wr_outstanding = count[1];

    for (genvar p = 0; p < 2; p++) begin : g_path
        state_e        state_q, state_d;
        logic [PW-1:0] main_q, main_d, skid_q, skid_d;
        logic [7:0]    cnt_q, cnt_d;
        logic          ready_q, ready_d;
        logic          push, pop, dec;
        logic [9:0]    load;

        assign push = in_valid[p] & ready_q;
        assign pop  = (state_q != StEmpty) & out_ready[p];
        // A completion with nothing outstanding is dropped so the count cannot underflow.
        assign dec  = dec_ev[p] & (cnt_q != 8'd0);

        always_ff @(posedge user_clk or negedge user_reset_n) begin
            if (!user_reset_n) begin
                state_q <= StEmpty;
                main_q  <= '0;
                skid_q  <= '0;
                cnt_q   <= '0;
                ready_q <= 1'b0;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
                cnt_q   <= cnt_d;
                ready_q <= ready_d;
            end
        end

        always_comb begin
            state_d = state_q;
            unique case (state_q)
                StEmpty: if (push) state_d = StOne;
                StOne: begin
                    if (push && !pop)      state_d = StTwo;
                    else if (!push && pop) state_d = StEmpty;
                end
                StTwo:   if (pop) state_d = StOne;
                default: state_d = StEmpty;
            endcase
        end

        always_comb begin
            main_d = main_q;
            skid_d = skid_q;
            unique case (state_q)
                StEmpty: if (push) main_d = in_payload[p];
                StOne: begin
                    if (push && pop) main_d = in_payload[p];
                    else if (push)   skid_d = in_payload[p];
                end
                StTwo:   if (pop) main_d = skid_q;
                default: ;
            endcase
            cnt_d = cnt_q + {7'd0, pop} - {7'd0, dec};
            // Buffered entries count against the limit, so accepting one more can never
            // push the outstanding count past MAX_OUT.
            load  = {2'b00, cnt_d} + ((state_d == StTwo) ? 10'd2 :
                                      (state_d == StOne) ? 10'd1 : 10'd0);
            ready_d = (state_d != StTwo) && (load < MaxOut);
        end

        assign in_ready[p]    = ready_q;
        assign out_valid[p]   = (state_q != StEmpty);
        assign out_payload[p] = main_q;
        assign count[p]       = cnt_q;
    end

`ifdef REMAP_WINDOW_CHECK_EN
    logic              err_valid_q, err_valid_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              ar_viol, aw_viol;

    assign ar_viol = in_valid[0] & in_ready[0] & (s_ar.addr >= WIN_SIZE);
    assign aw_viol = in_valid[1] & in_ready[1] & (s_aw.addr >= WIN_SIZE);

    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (err_clr) err_valid_d = 1'b0;
        // First error is held; a violation in the clear cycle re-arms the report.
        if (!err_valid_q || err_clr) begin
            if (ar_viol) begin
                err_valid_d = 1'b1;
                err_addr_d  = s_ar.addr;
            end else if (aw_viol) begin
                err_valid_d = 1'b1;
                err_addr_d  = s_aw.addr;
            end
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
`else
    localparam logic [ADDR_W-1:0] unused_win_size = WIN_SIZE;
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err_valid      = 1'b0;
    assign err_addr       = '0;
`endif

endmodule

// File: tb/tb_axi_addr_remap_slice.sv
// Scoreboard bench for axi_addr_remap_slice: directed AR/AW traffic, backpressure, limits, reset.
module tb_axi_addr_remap_slice;

    typedef logic [44:0] pl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mon_rv, mon_rr, mon_rl, mon_bv, mon_br, err_clr;
    logic [7:0]  rd_out, wr_out;
    logic        err_valid;
    logic [31:0] err_addr;
    logic        r2_evt;
    logic [7:0]  rd2_out, wr2_out;
    logic        err2_valid;
    logic [31:0] err2_addr;

    int  n_vec = 0;
    int  n_err = 0;
    pl_t exp_ar[$];
    pl_t exp_aw[$];

    always #5 clk = ~clk;

    axi_addr_remap_slice_if #(.ADDR_W(32), .LEN_W(8)) ar_if ();
    axi_addr_remap_slice_if #(.ADDR_W(32), .LEN_W(8)) aw_if ();
    axi_addr_remap_slice_if #(.ADDR_W(32), .LEN_W(8)) mar_if ();
    axi_addr_remap_slice_if #(.ADDR_W(32), .LEN_W(8)) maw_if ();
    axi_addr_remap_slice_if #(.ADDR_W(32), .LEN_W(8)) ar2_if ();
    axi_addr_remap_slice_if #(.ADDR_W(32), .LEN_W(8)) aw2_if ();
    axi_addr_remap_slice_if #(.ADDR_W(32), .LEN_W(8)) mar2_if ();
    axi_addr_remap_slice_if #(.ADDR_W(32), .LEN_W(8)) maw2_if ();

    axi_addr_remap_slice #(.MAX_OUT(8)) dut (
        .user_clk(clk), .user_reset_n(rst_n),
        .s_ar(ar_if), .s_aw(aw_if), .m_ar(mar_if), .m_aw(maw_if),
        .mon_rvalid(mon_rv), .mon_rready(mon_rr), .mon_rlast(mon_rl),
        .mon_bvalid(mon_bv), .mon_bready(mon_br),
        .rd_outstanding(rd_out), .wr_outstanding(wr_out),
        .err_valid(err_valid), .err_addr(err_addr), .err_clr(err_clr)
    );

    axi_addr_remap_slice #(.MAX_OUT(2)) dut2 (
        .user_clk(clk), .user_reset_n(rst_n),
        .s_ar(ar2_if), .s_aw(aw2_if), .m_ar(mar2_if), .m_aw(maw2_if),
        .mon_rvalid(r2_evt), .mon_rready(r2_evt), .mon_rlast(r2_evt),
        .mon_bvalid(1'b0), .mon_bready(1'b0),
        .rd_outstanding(rd2_out), .wr_outstanding(wr2_out),
        .err_valid(err2_valid), .err_addr(err2_addr), .err_clr(1'b0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [31:0] ea, input bit fwd);
        int k;
        ar_if.valid = 1'b1; ar_if.addr = a; ar_if.len = l; ar_if.size = s; ar_if.burst = b;
        k = 0;
        do begin @(negedge clk); k++; end while (!ar_if.ready && k < 50);
        n_vec++;
        if (!ar_if.ready) begin
            n_err++;
            $display("FAIL ar_accept: s_arready=0 after %0d cycles, required 1", k);
        end else if (fwd) exp_ar.push_back({ea, l, s, b});
        @(posedge clk); #1;
        ar_if.valid = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [31:0] ea, input bit fwd);
        int k;
        aw_if.valid = 1'b1; aw_if.addr = a; aw_if.len = l; aw_if.size = s; aw_if.burst = b;
        k = 0;
        do begin @(negedge clk); k++; end while (!aw_if.ready && k < 50);
        n_vec++;
        if (!aw_if.ready) begin
            n_err++;
            $display("FAIL aw_accept: s_awready=0 after %0d cycles, required 1", k);
        end else if (fwd) exp_aw.push_back({ea, l, s, b});
        @(posedge clk); #1;
        aw_if.valid = 1'b0;
    endtask

    task automatic r_pulse();
        mon_rv = 1'b1; mon_rr = 1'b1; mon_rl = 1'b1;
        @(posedge clk); #1;
        mon_rv = 1'b0; mon_rr = 1'b0; mon_rl = 1'b0;
    endtask

    task automatic b_pulse();
        mon_bv = 1'b1; mon_br = 1'b1;
        @(posedge clk); #1;
        mon_bv = 1'b0; mon_br = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every downstream handshake and checks stall stability.
    initial begin
        pl_t cur_ar, cur_aw, held_ar, held_aw, e;
        bit  hold_ar, hold_aw;
        hold_ar = 1'b0; hold_aw = 1'b0; held_ar = '0; held_aw = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_ar = 1'b0; hold_aw = 1'b0;
            end else begin
                cur_ar = {mar_if.addr, mar_if.len, mar_if.size, mar_if.burst};
                cur_aw = {maw_if.addr, maw_if.len, maw_if.size, maw_if.burst};
                if (hold_ar) begin
                    n_vec++;
                    if (!mar_if.valid || cur_ar !== held_ar) begin
                        n_err++;
                        $display("FAIL ar_stable: got valid=%0b payload=0x%h, required valid=1 payload=0x%h",
                                 mar_if.valid, cur_ar, held_ar);
                    end
                end
                if (hold_aw) begin
                    n_vec++;
                    if (!maw_if.valid || cur_aw !== held_aw) begin
                        n_err++;
                        $display("FAIL aw_stable: got valid=%0b payload=0x%h, required valid=1 payload=0x%h",
                                 maw_if.valid, cur_aw, held_aw);
                    end
                end
                hold_ar = mar_if.valid && !mar_if.ready; held_ar = cur_ar;
                hold_aw = maw_if.valid && !maw_if.ready; held_aw = cur_aw;
                if (mar_if.valid && mar_if.ready) begin
                    n_vec++;
                    if (exp_ar.size() == 0) begin
                        n_err++;
                        $display("FAIL ar_unexpected: got payload=0x%h, required no transfer", cur_ar);
                    end else begin
                        e = exp_ar.pop_front();
                        if (cur_ar !== e) begin
                            n_err++;
                            $display("FAIL ar_payload: got 0x%h, required 0x%h", cur_ar, e);
                        end
                    end
                end
                if (maw_if.valid && maw_if.ready) begin
                    n_vec++;
                    if (exp_aw.size() == 0) begin
                        n_err++;
                        $display("FAIL aw_unexpected: got payload=0x%h, required no transfer", cur_aw);
                    end else begin
                        e = exp_aw.pop_front();
                        if (cur_aw !== e) begin
                            n_err++;
                            $display("FAIL aw_payload: got 0x%h, required 0x%h", cur_aw, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst_n = 1'b0;
        mon_rv = 1'b0; mon_rr = 1'b0; mon_rl = 1'b0; mon_bv = 1'b0; mon_br = 1'b0;
        err_clr = 1'b0; r2_evt = 1'b0;
        ar_if.valid = 1'b0; ar_if.addr = '0; ar_if.len = '0; ar_if.size = '0; ar_if.burst = '0;
        aw_if.valid = 1'b0; aw_if.addr = '0; aw_if.len = '0; aw_if.size = '0; aw_if.burst = '0;
        ar2_if.valid = 1'b0; ar2_if.addr = '0; ar2_if.len = '0; ar2_if.size = '0; ar2_if.burst = '0;
        aw2_if.valid = 1'b0; aw2_if.addr = '0; aw2_if.len = '0; aw2_if.size = '0; aw2_if.burst = '0;
        mar_if.ready = 1'b0; maw_if.ready = 1'b0; mar2_if.ready = 1'b1; maw2_if.ready = 1'b1;

        // Reset state
        #12;
        check("rst_arready", ar_if.ready, 0);
        check("rst_awready", aw_if.ready, 0);
        check("rst_marvalid", mar_if.valid, 0);
        check("rst_mawvalid", maw_if.valid, 0);
        check("rst_counts", {rd_out, wr_out}, 0);
        check("rst_err", {31'd0, err_valid} | err_addr, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rel_arready", ar_if.ready, 1);
        check("rel_awready", aw_if.ready, 1);

        // Basic remap, latency, counter
        mar_if.ready = 1'b1; maw_if.ready = 1'b1;
        @(posedge clk); #1;
        send_ar(32'h0000_1000, 8'd3, 3'd2, 2'd1, 32'h4000_1000, 1'b1);
        @(negedge clk) check("ar_latency", mar_if.valid, 1);
        @(negedge clk) check("rd_out_1", rd_out, 1);
        @(posedge clk); #1;
        r_pulse();
        @(negedge clk) check("rd_out_dec", rd_out, 0);
        @(posedge clk); #1;
        r_pulse();
        @(negedge clk) check("rd_out_sat0", rd_out, 0);

        // Address wrap
        @(posedge clk); #1;
        send_ar(32'hC000_0010, 8'd0, 3'd3, 2'd2, 32'h0000_0010, 1'b1);
        @(negedge clk);
        @(negedge clk) check("rd_out_wrap", rd_out, 1);

        // Increment and decrement in the same cycle
        @(posedge clk); #1;
        send_ar(32'h0000_0040, 8'd15, 3'd2, 2'd1, 32'h4000_0040, 1'b1);
        r_pulse();
        @(negedge clk) check("rd_inc_dec", rd_out, 1);
        @(posedge clk); #1;
        r_pulse();
        @(negedge clk) check("rd_drain", rd_out, 0);

        // AW backpressure: two accepted, third stalls, then in-order release
        maw_if.ready = 1'b0;
        @(posedge clk); #1;
        aw_if.valid = 1'b1; aw_if.addr = 32'h100; aw_if.len = 8'd1; aw_if.size = 3'd2; aw_if.burst = 2'd1;
        @(negedge clk) check("aw_rdy_a", aw_if.ready, 1);
        exp_aw.push_back({32'h4000_0100, 8'd1, 3'd2, 2'd1});
        @(posedge clk); #1;
        aw_if.addr = 32'h200; aw_if.len = 8'd2;
        @(negedge clk) check("aw_rdy_b", aw_if.ready, 1);
        exp_aw.push_back({32'h4000_0200, 8'd2, 3'd2, 2'd1});
        @(posedge clk); #1;
        aw_if.addr = 32'h300; aw_if.len = 8'd3; aw_if.size = 3'd1; aw_if.burst = 2'd0;
        @(negedge clk) check("aw_full", aw_if.ready, 0);
        for (int i = 0; i < 3; i++) @(negedge clk) check("aw_full_hold", aw_if.ready, 0);
        check("aw_payload_hold", maw_if.addr, 32'h4000_0100);
        @(posedge clk); #1;
        maw_if.ready = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!aw_if.ready && k < 20);
        check("aw_rdy_c", aw_if.ready, 1);
        if (aw_if.ready) exp_aw.push_back({32'h4000_0300, 8'd3, 3'd1, 2'd0});
        @(posedge clk); #1;
        aw_if.valid = 1'b0;
        repeat (3) @(negedge clk);
        check("wr_out_3", wr_out, 3);
        @(posedge clk); #1;
        b_pulse(); b_pulse(); b_pulse();
        @(negedge clk) check("wr_drain", wr_out, 0);

        // MAX_OUT=2 instance: limit closes and reopens
        @(posedge clk); #1;
        ar2_if.valid = 1'b1; ar2_if.addr = 32'h10;
        @(negedge clk) check("m2_rdy_first", ar2_if.ready, 1);
        @(posedge clk); #1;
        @(negedge clk) check("m2_rdy_second", ar2_if.ready, 1);
        @(posedge clk); #1;
        ar2_if.valid = 1'b0;
        @(negedge clk) check("m2_full", ar2_if.ready, 0);
        @(negedge clk) check("m2_full_hold", ar2_if.ready, 0);
        check("m2_rd_out", rd2_out, 2);
        @(posedge clk); #1;
        r2_evt = 1'b1;
        @(posedge clk); #1;
        r2_evt = 1'b0;
        @(negedge clk) check("m2_reopen", ar2_if.ready, 1);
        check("m2_rd_dec", rd2_out, 1);

        // Reset with both buffers full
        @(posedge clk); #1;
        send_ar(32'h0000_2000, 8'd0, 3'd2, 2'd1, 32'h4000_2000, 1'b1);
        @(posedge clk); #1;
        mar_if.ready = 1'b0; maw_if.ready = 1'b0;
        send_ar(32'h0000_3000, 8'd1, 3'd2, 2'd1, 32'h0, 1'b0);
        send_ar(32'h0000_3100, 8'd1, 3'd2, 2'd1, 32'h0, 1'b0);
        send_aw(32'h0000_4000, 8'd1, 3'd2, 2'd1, 32'h0, 1'b0);
        send_aw(32'h0000_4100, 8'd1, 3'd2, 2'd1, 32'h0, 1'b0);
        check("pre_rst_ar_full", ar_if.ready, 0);
        check("pre_rst_aw_full", aw_if.ready, 0);
        check("pre_rst_rd_out", rd_out, 1);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_marvalid", mar_if.valid, 0);
        check("mid_rst_mawvalid", maw_if.valid, 0);
        check("mid_rst_counts", {rd_out, wr_out}, 0);
        check("mid_rst_ready", {ar_if.ready, aw_if.ready}, 0);
        @(negedge clk) rst_n = 1'b1;
        mar_if.ready = 1'b1; maw_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk) check("no_stale", {mar_if.valid, maw_if.valid}, 0);

        // Window edge and violation reporting
        @(posedge clk); #1;
        send_ar(32'h0FFF_FFFC, 8'hFF, 3'd0, 2'd0, 32'h4FFF_FFFC, 1'b1);
        @(negedge clk);
        @(negedge clk) check("win_edge_noerr", err_valid, 0);
        @(posedge clk); #1;
        send_aw(32'h2000_0000, 8'd4, 3'd2, 2'd1, 32'h6000_0000, 1'b1);
        @(negedge clk);
`ifdef REMAP_WINDOW_CHECK_EN
        check("win_err_valid", err_valid, 1);
        check("win_err_addr", err_addr, 32'h2000_0000);
        @(posedge clk); #1;
        send_ar(32'h3000_0000, 8'd0, 3'd2, 2'd1, 32'h7000_0000, 1'b1);
        @(negedge clk);
        check("win_second_addr", err_addr, 32'h2000_0000);
        check("win_second_valid", err_valid, 1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk) check("win_clr", err_valid, 0);
`else
        check("win_off_valid", err_valid, 0);
        check("win_off_addr", err_addr, 0);
`endif

        k = 0;
        while ((exp_ar.size() + exp_aw.size()) != 0 && k < 20) begin @(negedge clk); k++; end
        check("sb_drain", exp_ar.size() + exp_aw.size(), 0);
        check("m2_idle", {23'd0, err2_valid, wr2_out} | err2_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
